// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and funct3 constants for the load/store unit
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      READ     = 3'd1,
      LOAD_RSP = 3'd2,
      WRITE    = 3'd3,
      ERR      = 3'd4
   } lsu_state_t;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - legality/alignment check, load extract/extend, store lane merge
module lsu_align
   import lsu_pkg::*;
(
   input  logic        chk_we_i,
   input  logic [2:0]  chk_funct3_i,
   input  logic [1:0]  chk_lane_i,
   output logic        chk_err_o,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  lane_i,
   input  logic [15:0] wdata_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merge_data_o
);

   logic [4:0]  shamt;
   logic [31:0] shifted;
   logic [31:0] lane_mask;
   logic [31:0] lane_data;

   always_comb begin
      chk_err_o = 1'b1;
      if (chk_we_i) begin
         case (chk_funct3_i)
            F3_B:    chk_err_o = 1'b0;
            F3_H:    chk_err_o = chk_lane_i[0];
            F3_W:    chk_err_o = |chk_lane_i;
            default: chk_err_o = 1'b1;
         endcase
      end else begin
         case (chk_funct3_i)
            F3_B, F3_BU: chk_err_o = 1'b0;
            F3_H, F3_HU: chk_err_o = chk_lane_i[0];
            F3_W:        chk_err_o = |chk_lane_i;
            default:     chk_err_o = 1'b1;
         endcase
      end
   end

   // A legal halfword has lane[0]=0, so one byte-granular shift serves both sizes.
   assign shamt   = {lane_i, 3'b000};
   assign shifted = mem_rdata_i >> shamt;

   always_comb begin
      load_data_o = mem_rdata_i;
      case (funct3_i)
         F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   load_data_o = {24'h000000, shifted[7:0]};
         F3_HU:   load_data_o = {16'h0000, shifted[15:0]};
         default: load_data_o = mem_rdata_i;
      endcase
   end

   always_comb begin
      lane_mask = 32'hFFFF_FFFF;
      lane_data = 32'h0000_0000;
      case (funct3_i)
         F3_B: begin
            lane_mask = 32'h0000_00FF << shamt;
            lane_data = {24'h000000, wdata_i[7:0]} << shamt;
         end
         F3_H: begin
            lane_mask = 32'h0000_FFFF << shamt;
            lane_data = {16'h0000, wdata_i} << shamt;
         end
         default: begin
            lane_mask = 32'hFFFF_FFFF;
            lane_data = {16'h0000, wdata_i};
         end
      endcase
   end

   assign merge_data_o = (mem_rdata_i & ~lane_mask) | (lane_data & lane_mask);

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit in front of a word-only synchronous-read memory
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic [31:0] mem_read_addr,
   input  logic [31:0] mem_read_data,
   output logic [31:0] mem_write_addr,
   output logic [31:0] mem_write_data,
   output logic        mem_write_enable
);

   lsu_state_t  state_q, state_d;
   lsu_req_t    req_q, req_d;
   logic        accept;
   logic        in_err;
   logic [31:0] load_data;
   logic [31:0] merge_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
      end
   end

   assign req_ready = rst && (state_q == IDLE);
   assign accept    = req_valid && req_ready;

   always_comb begin
      req_d = req_q;
      if (accept) begin
         req_d.we     = req_we;
         req_d.funct3 = req_funct3;
         req_d.addr   = req_addr;
         req_d.wdata  = req_wdata;
      end
   end

   // The incoming check steers the accept transition; extract/merge work on the captured request.
   lsu_align u_align (
      .chk_we_i     (req_we),
      .chk_funct3_i (req_funct3),
      .chk_lane_i   (req_addr[1:0]),
      .chk_err_o    (in_err),
      .funct3_i     (req_q.funct3),
      .lane_i       (req_q.addr[1:0]),
      .wdata_i      (req_q.wdata[15:0]),
      .mem_rdata_i  (mem_read_data),
      .load_data_o  (load_data),
      .merge_data_o (merge_data)
   );

   assign mem_read_addr  = {req_q.addr[31:2], 2'b00};
   assign mem_write_addr = {req_q.addr[31:2], 2'b00};

   always_comb begin
      state_d          = state_q;
      rsp_valid        = 1'b0;
      rsp_err          = 1'b0;
      rsp_rdata        = 32'h0000_0000;
      mem_write_enable = 1'b0;
      mem_write_data   = 32'h0000_0000;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (in_err)
                  state_d = ERR;
               else if (req_we && (req_funct3 == F3_W))
                  state_d = WRITE;
               else
                  state_d = READ;
            end
         end
         READ: begin
            state_d = req_q.we ? WRITE : LOAD_RSP;
         end
         LOAD_RSP: begin
            rsp_valid = 1'b1;
            rsp_rdata = load_data;
            state_d   = IDLE;
         end
         WRITE: begin
            mem_write_enable = 1'b1;
            mem_write_data   = (req_q.funct3 == F3_W) ? req_q.wdata : merge_data;
            rsp_valid        = 1'b1;
            state_d          = IDLE;
         end
         ERR: begin
            rsp_valid = 1'b1;
            rsp_err   = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] mem_read_addr;
   logic [31:0] mem_read_data;
   logic [31:0] mem_write_addr;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;

   logic [31:0] tb_mem  [0:127];
   logic [31:0] ref_mem [0:127];
   int checks = 0;
   int failures = 0;
   int wr_cnt = 0;

   load_store_unit dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_we           (req_we),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .rsp_valid        (rsp_valid),
      .rsp_err          (rsp_err),
      .rsp_rdata        (rsp_rdata),
      .mem_read_addr    (mem_read_addr),
      .mem_read_data    (mem_read_data),
      .mem_write_addr   (mem_write_addr),
      .mem_write_data   (mem_write_data),
      .mem_write_enable (mem_write_enable)
   );

   always #5 clk = ~clk;

   // memoryData: word-only, read-first, decodes addr[8:2]
   always @(posedge clk) begin
      mem_read_data <= tb_mem[mem_read_addr[8:2]];
      if (mem_write_enable) begin
         tb_mem[mem_write_addr[8:2]] = mem_write_data;
         wr_cnt = wr_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: RV32 load/store semantics on a word array, updated on stores.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                        output int lat, output int writes, output int idx);
      int size, off;
      logic legal;
      longint mask, v, word;
      off = int'(addr % 4);
      idx = int'((addr / 4) % 128);
      case (f3[1:0])
         2'd0: size = 1;
         2'd1: size = 2;
         default: size = 4;
      endcase
      legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
      err = !legal || ((addr % size) != 0);
      rdata = 32'h0;
      writes = 0;
      lat = 1;
      mask = (64'd1 << (8 * size)) - 1;
      word = longint'(ref_mem[idx]);
      if (!err) begin
         if (!we) begin
            lat = 2;
            v = (word >> (8 * off)) & mask;
            if (f3[2] == 1'b0 && size < 4 && v >= (mask + 1) / 2)
               v = v - (mask + 1);
            rdata = v[31:0];
         end else begin
            writes = 1;
            lat = (size == 4) ? 1 : 2;
            v = (word & ~(mask << (8 * off))) | ((longint'(wd) & mask) << (8 * off));
            ref_mem[idx] = v[31:0];
         end
      end
   endtask

   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] got, output logic got_err);
      logic e_err;
      logic [31:0] e_rd;
      int e_lat, e_wr, idx, n, w0;
      model(we, f3, addr, wd, e_err, e_rd, e_lat, e_wr, idx);
      @(negedge clk);
      req_valid = 1'b1;
      req_we = we;
      req_funct3 = f3;
      req_addr = addr;
      req_wdata = wd;
      n = 0;
      while (!req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      w0 = wr_cnt;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 6) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_latency"}, n, e_lat);
      chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e_err});
      chk({tag, "_rdata"}, rsp_rdata, e_rd);
      got = rsp_rdata;
      got_err = rsp_err;
      if (e_wr != 0) begin
         chk({tag, "_we"}, {31'd0, mem_write_enable}, 32'd1);
         chk({tag, "_waddr"}, mem_write_addr, {addr[31:2], 2'b00});
         chk({tag, "_wdata"}, mem_write_data, ref_mem[idx]);
      end
      @(negedge clk);
      chk({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_writes"}, wr_cnt - w0, e_wr);
      chk({tag, "_mem"}, tb_mem[idx], ref_mem[idx]);
   endtask

   initial begin
      logic [31:0] got;
      logic        gerr;
      logic        e_err;
      logic [31:0] e_rd;
      int          e_lat, e_wr, idx, w0;

      for (int i = 0; i < 128; i++) begin
         tb_mem[i] = $urandom;
         ref_mem[i] = tb_mem[i];
      end

      // Reset values
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_we", {31'd0, mem_write_enable}, 32'd0);
      chk("rst_raddr", mem_read_addr, 32'd0);
      chk("rst_waddr", mem_write_addr, 32'd0);
      chk("rst_wdata", mem_write_data, 32'd0);
      rst = 1'b1;
      #1;
      chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

      // 1: SW / LW
      do_req("t1_sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, got, gerr);
      do_req("t1_lw", 1'b0, 3'b010, 32'h10, 32'h0, got, gerr);
      chk("t1_lw_value", got, 32'hDEADBEEF);
      // 2: SB / LB / LBU
      do_req("t2_sb", 1'b1, 3'b000, 32'h12, 32'h000000AA, got, gerr);
      chk("t2_word", tb_mem[4], 32'hDEAABEEF);
      do_req("t2_lb", 1'b0, 3'b000, 32'h12, 32'h0, got, gerr);
      chk("t2_lb_value", got, 32'hFFFFFFAA);
      do_req("t2_lbu", 1'b0, 3'b100, 32'h12, 32'h0, got, gerr);
      chk("t2_lbu_value", got, 32'h000000AA);
      // 3: SH / LH / LHU
      do_req("t3_sh", 1'b1, 3'b001, 32'h12, 32'h00008001, got, gerr);
      chk("t3_word", tb_mem[4], 32'h8001BEEF);
      do_req("t3_lh", 1'b0, 3'b001, 32'h12, 32'h0, got, gerr);
      chk("t3_lh_value", got, 32'hFFFF8001);
      do_req("t3_lhu", 1'b0, 3'b101, 32'h12, 32'h0, got, gerr);
      chk("t3_lhu_value", got, 32'h00008001);
      // 4: errors
      do_req("t4_lw13", 1'b0, 3'b010, 32'h13, 32'h0, got, gerr);
      chk("t4_lw13_err", {31'd0, gerr}, 32'd1);
      do_req("t4_sh11", 1'b1, 3'b001, 32'h11, 32'h12345678, got, gerr);
      chk("t4_sh11_err", {31'd0, gerr}, 32'd1);
      do_req("t4_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, got, gerr);
      chk("t4_f3_err", {31'd0, gerr}, 32'd1);
      chk("t4_word", tb_mem[4], 32'h8001BEEF);

      // 5: reset during READ of an SB
      w0 = wr_cnt;
      @(negedge clk);
      req_valid = 1'b1;
      req_we = 1'b1;
      req_funct3 = 3'b000;
      req_addr = 32'h10;
      req_wdata = 32'h55;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("t5_we_drop", {31'd0, mem_write_enable}, 32'd0);
      chk("t5_ready_low", {31'd0, req_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("t5_ready", {31'd0, req_ready}, 32'd1);
      chk("t5_no_rsp_after", {31'd0, rsp_valid}, 32'd0);
      chk("t5_writes", wr_cnt - w0, 32'd0);
      chk("t5_word", tb_mem[4], 32'h8001BEEF);

      // 6: back-to-back with req_valid held high, aliasing 0x200 -> 0x0
      model(1'b1, 3'b010, 32'h200, 32'h1, e_err, e_rd, e_lat, e_wr, idx);
      model(1'b0, 3'b010, 32'h0, 32'h0, e_err, e_rd, e_lat, e_wr, idx);
      @(negedge clk);
      req_valid = 1'b1;
      req_we = 1'b1;
      req_funct3 = 3'b010;
      req_addr = 32'h200;
      req_wdata = 32'h1;
      chk("t6_ready0", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("t6_sw_rsp", {31'd0, rsp_valid}, 32'd1);
      chk("t6_sw_we", {31'd0, mem_write_enable}, 32'd1);
      chk("t6_sw_waddr", mem_write_addr, 32'h200);
      chk("t6_sw_wdata", mem_write_data, 32'h1);
      chk("t6_ready1", {31'd0, req_ready}, 32'd0);
      req_we = 1'b0;
      req_addr = 32'h0;
      req_wdata = 32'h0;
      @(negedge clk);
      chk("t6_ready2", {31'd0, req_ready}, 32'd1);
      chk("t6_rsp2", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      chk("t6_lw_c1", {31'd0, rsp_valid}, 32'd0);
      chk("t6_lw_raddr", mem_read_addr, 32'h0);
      @(negedge clk);
      chk("t6_lw_rsp", {31'd0, rsp_valid}, 32'd1);
      chk("t6_lw_err", {31'd0, rsp_err}, 32'd0);
      chk("t6_lw_data", rsp_rdata, 32'h00000001);
      chk("t6_lw_model", rsp_rdata, e_rd);

      // Randomized requests against the reference model
      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 3) << 9) | $urandom_range(0, 31);
         do_req("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, got, gerr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the RV32 execute stage and the word-only, synchronous-read data memory (`memoryData`). It takes one load or store request at a time, enforces natural alignment, and converts byte and halfword stores into a read-modify-write of the containing word. It extracts and sign- or zero-extends load data. It returns exactly one response per accepted request.

## Interface
- No parameters. The data width is fixed at 32 and the memory word address is `addr[31:2]`.
- `clk`  in  1  Single clock. The data memory uses the same clock.
- `rst`  in  1  Asynchronous, active-low reset.
- `req_valid`  in  1  A request is present.
- `req_ready`  out  1  The unit can accept a request. High only in IDLE. Low while `rst` is asserted.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32 funct3 encoding:
  - Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Stores: SB=000, SH=001, SW=010.
- `req_addr`  in  32  Byte address.
- `req_wdata`  in  32  Store data. Right-aligned: the byte or halfword is in the low bits.
- `rsp_valid`  out  1  One-cycle response pulse. Cannot be stalled.
- `rsp_err`  out  1  The request was misaligned or used an illegal funct3. Valid only with `rsp_valid`.
- `rsp_rdata`  out  32  Extended load data. 0 for stores and for errors.
- `mem_read_addr`  out  32  Word-aligned address (low 2 bits are 0).
- `mem_read_data`  in  32  Memory output. Valid one cycle after the address is sampled.
- `mem_write_addr`  out  32  Word-aligned address.
- `mem_write_data`  out  32  Full word to write.
- `mem_write_enable`  out  1  Write strobe.

## Operation
- The request is accepted on the rising edge where `req_valid && req_ready`. All request fields are captured into registers at that edge.
- A request is an error if any of the following holds:
  - funct3 is not legal for the direction (loads: 011, 110, 111; stores: anything other than 000, 001, 010);
  - it is a halfword access with `addr[0]=1`;
  - it is a word access with `addr[1:0]!=0`.
  - Error requests never touch memory.
- State machine, with IDLE as the reset state:
  - IDLE: on accept, go to ERR if the request is an error; else go to WRITE for SW; else go to READ (loads, SB, SH).
  - READ: drive `mem_read_addr = {addr[31:2],2'b00}`. Go to LOAD_RSP for a load, or WRITE for SB/SH.
  - LOAD_RSP: extract the byte or halfword selected by `addr[1:0]` from `mem_read_data`. Sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes the word through. Pulse `rsp_valid`, then go to IDLE.
  - WRITE: assert `mem_write_enable`, with `mem_write_addr` = the word-aligned address.
    - For SW, write `req_wdata`.
    - For SB/SH, write `mem_read_data` with only the addressed lane(s) replaced by the low 8 or 16 bits of `req_wdata`.
    - Pulse `rsp_valid` with `rsp_rdata=0`, then go to IDLE.
  - ERR: pulse `rsp_valid` with `rsp_err=1` and `rsp_rdata=0`, then go to IDLE.
- No range check is done. The memory decodes only `addr[8:2]`, so addresses alias every 0x200 bytes.
- Reset mid-operation: the FSM goes to IDLE asynchronously and `mem_write_enable` drops immediately. The in-flight request is dropped with no response. Memory contents are not touched by this reset.

## Timing
- Let cycle 0 be the accept cycle.
- Load: `mem_read_addr` is valid in cycle 1. `rsp_valid` and data arrive in cycle 2. The next accept can happen in cycle 3.
- SW: write and `rsp_valid` both occur in cycle 1. The next accept can happen in cycle 2.
- SB/SH: read in cycle 1, then write and `rsp_valid` in cycle 2. The next accept can happen in cycle 3.
- Error: `rsp_valid` in cycle 1.
- Memory outputs (`mem_*`) and `rsp_*` are decoded from the state and captured registers, with `rsp_rdata` and the merge data also depending on `mem_read_data`. There is no combinational path from `req_*` to `mem_*` or `rsp_*`.
- `req_ready` is decoded from the state.
- Reset values:
  - `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`;
  - `mem_write_enable=0`, `mem_read_addr=0`, `mem_write_addr=0`, `mem_write_data=0`;
  - `req_ready=0` while `rst` is low, 1 after release.
- Non-error requests never overlap, so there is no read/write hazard on the same word.

## Structure
- Package `lsu_pkg` holds:
  - the funct3 constants;
  - the state enum `lsu_state_t` (IDLE, READ, LOAD_RSP, WRITE, ERR);
  - the request struct `lsu_req_t` (we, funct3, addr, wdata).
- Sub-module `lsu_align` is purely combinational and contains the alignment/legality check, the load extract/extend, and the store lane merge.

## Test plan
1. SW to 0x10 with data 0xDEADBEEF: `mem_write_enable` is high for exactly one cycle (cycle 1) with `mem_write_addr=0x10`. Then LW from 0x10 returns `rsp_rdata=0xDEADBEEF` in cycle 2.
2. Starting from test 1, SB to 0x12 with data 0x000000AA: the word becomes 0xDEAABEEF. Then LB from 0x12 returns 0xFFFFFFAA, and LBU from 0x12 returns 0x000000AA.
3. SH to 0x12 with data 0x00008001: the word becomes 0x8001BEEF. Then LH from 0x12 returns 0xFFFF8001, and LHU from 0x12 returns 0x00008001.
4. LW from 0x13, SH to 0x11, and a load with funct3 011 each give `rsp_err=1` in cycle 1 with `rsp_rdata=0`. `mem_write_enable` never asserts and the word at 0x10 is unchanged.
5. Assert `rst` low during the READ cycle of an SB: `mem_write_enable` never asserts, there is no `rsp_valid`, the memory word is unchanged, and `req_ready=1` after release.
6. Hold `req_valid` high with SW to 0x200 (data 0x1) followed by LW from 0x0. The second request is accepted only when `req_ready` returns in cycle 2. The LW returns 0x00000001 (aliasing).
